// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the multiply sequencer: FSM state encoding,
// default timing parameters and the unsigned-correction helper.
package mul_seq_ctrl_pkg;

   localparam int DEFAULT_MUL_CYCLES = 2;
   localparam int DEFAULT_CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      WRITE = 2'd2
   } state_t;

   // Turns a 64-bit signed product into the unsigned product of the same bit
   // patterns: each operand with its top bit set was read as (x - 2**32), so
   // the other operand shifted up by 32 is added back (mod 2**64).
   function automatic logic [63:0] unsigned_correct(input logic [63:0] p,
                                                    input logic [31:0] a,
                                                    input logic [31:0] b);
      logic [63:0] corr_a;
      logic [63:0] corr_b;
      corr_a = a[31] ? {b, 32'b0} : 64'b0;
      corr_b = b[31] ? {a, 32'b0} : 64'b0;
      return p + corr_a + corr_b;
   endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Request/response bundle between the control unit and the multiply
// sequencer. The control unit is the master, the sequencer the slave.
interface mul_seq_ctrl_if;

   logic        start;
   logic        is_unsigned;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        ready;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, is_unsigned, op_a, op_b,
      input  ready, busy, done, hi, lo
   );

   modport slave (
      input  start, is_unsigned, op_a, op_b,
      output ready, busy, done, hi, lo
   );

endinterface

// File: rtl/mul_seq_ctrl_mul_32_bit.sv
// Combinational 32x32 signed radix-4 Booth multiplier. The multiplier
// operand b is recoded into 16 digits in {-2,-1,0,+1,+2}; each selects a
// multiple of the sign-extended multiplicand, shifted by two bits per digit.
// This is a long combinational path, which is why the sequencer holds its
// inputs for several clocks before sampling the product.
module mul_32_bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] p
);

   logic [32:0] b_ext;
   logic [63:0] a_sx;

   assign b_ext = {b, 1'b0};
   assign a_sx  = {{32{a[31]}}, a};

   // Maps one Booth digit (b[2i+1], b[2i], b[2i-1]) onto its partial product.
   function automatic logic [63:0] booth_pp(input logic [2:0] digit,
                                            input logic [63:0] m);
      logic [63:0] pp;
      case (digit)
         3'b001, 3'b010: pp = m;
         3'b011:         pp = m << 1;
         3'b100:         pp = -(m << 1);
         3'b101, 3'b110: pp = -m;
         default:        pp = 64'b0;
      endcase
      return pp;
   endfunction

   // Accumulates the sixteen shifted partial products into the product.
   always_comb begin
      p = 64'b0;
      for (int i = 0; i < 16; i++) begin
         p = p + (booth_pp(b_ext[2*i +: 3], a_sx) << (2 * i));
      end
   end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multiply sequencer: captures operands on start, holds them on the Booth
// multiplier for MUL_CYCLES clocks, applies the unsigned correction if
// requested and loads HI/LO. done is registered so that it rises in the same
// cycle the new HI/LO values appear at the outputs.
module mul_seq_ctrl
   import mul_seq_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = DEFAULT_MUL_CYCLES,
   parameter int CNT_W      = DEFAULT_CNT_W
) (
   input  logic           clk,
   input  logic           reset,
   mul_seq_ctrl_if.slave  bus
);

   state_t      state_q;
   state_t      state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic        uns_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;
   logic [63:0] prod_s;
   logic [63:0] prod_final;

   // The multiplier only ever sees the operand registers, so its inputs stay
   // stable for the whole multicycle settle window.
   mul_32_bit u_mul (
      .a (a_q),
      .b (b_q),
      .p (prod_s)
   );

   assign prod_final = uns_q ? unsigned_correct(prod_s, a_q, b_q) : prod_s;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic: CALC runs until the settle counter reaches zero and
   // ignores any start that arrives in the meantime.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = CALC;
         CALC:    if (cnt_q == '0) state_d = WRITE;
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand capture on accept and settle-counter countdown during CALC.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         uns_q <= 1'b0;
      end else if (state_q == IDLE && bus.start) begin
         cnt_q <= CNT_W'(MUL_CYCLES - 1);
         a_q   <= bus.op_a;
         b_q   <= bus.op_b;
         uns_q <= bus.is_unsigned;
      end else if (state_q == CALC && cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Result registers and the completion pulse; a reset while busy clears
   // HI/LO and suppresses the pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= (state_q == WRITE);
         if (state_q == WRITE) begin
            hi_q <= prod_final[63:32];
            lo_q <= prod_final[31:0];
         end
      end
   end

   assign bus.ready = (state_q == IDLE);
   assign bus.busy  = (state_q == CALC) || (state_q == WRITE);
   assign bus.done  = done_q;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Testbench for mul_seq_ctrl. Three instances (MUL_CYCLES = 1, 2, 3) share
// the same stimulus; directed tests observe the MUL_CYCLES=2 instance and
// the random phase checks all three against a behavioural product.
module tb_mul_seq_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic        is_unsigned;
   logic [31:0] op_a;
   logic [31:0] op_b;

   int n_checks;
   int n_fail;
   int cyc;

   mul_seq_ctrl_if bus1 ();
   mul_seq_ctrl_if bus2 ();
   mul_seq_ctrl_if bus3 ();

   assign bus1.start = start;  assign bus1.is_unsigned = is_unsigned;
   assign bus1.op_a  = op_a;   assign bus1.op_b        = op_b;
   assign bus2.start = start;  assign bus2.is_unsigned = is_unsigned;
   assign bus2.op_a  = op_a;   assign bus2.op_b        = op_b;
   assign bus3.start = start;  assign bus3.is_unsigned = is_unsigned;
   assign bus3.op_a  = op_a;   assign bus3.op_b        = op_b;

   mul_seq_ctrl #(.MUL_CYCLES(1), .CNT_W(4)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
   mul_seq_ctrl #(.MUL_CYCLES(2), .CNT_W(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
   mul_seq_ctrl #(.MUL_CYCLES(3), .CNT_W(4)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        uns;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        uns;
   } op_t;

   vec_t vecs[10];
   op_t  pend[$];

   function automatic logic [63:0] ref_product(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic uns);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      if (uns) return {32'b0, a} * {32'b0, b};
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_output(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic uns);
      op_a        = a;
      op_b        = b;
      is_unsigned = uns;
   endtask

   task automatic wait_ready2();
      int k;
      k = 0;
      while (!bus2.ready && k < 20) begin
         tick();
         k++;
      end
      check_output("ready_wait", 64'(bus2.ready), 64'd1);
   endtask

   // One multiply on the MUL_CYCLES=2 instance: latency and HI/LO checked.
   task automatic run_vector(input vec_t v, input int idx);
      int lat;
      wait_ready2();
      apply_stimulus(v.a, v.b, v.uns);
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10 && lat == 0; k++) begin
         tick();
         if (bus2.done) lat = k;
      end
      check_output($sformatf("latency_v%0d", idx), 64'(lat), 64'd3);
      check_output($sformatf("hi_v%0d", idx), 64'(bus2.hi), 64'(v.exp_hi));
      check_output($sformatf("lo_v%0d", idx), 64'(bus2.lo), 64'(v.exp_lo));
   endtask

   initial begin
      int accepted;
      int dones;
      int last_done;
      int n1, n2, n3;
      op_t o;
      logic [31:0] ra, rb;
      logic        ru;

      n_checks = 0; n_fail = 0; cyc = 0;
      start = 1'b0; reset = 1'b1;
      apply_stimulus(32'd0, 32'd0, 1'b0);

      vecs[0] = '{32'hFFFF_FFF9, 32'd6,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
      vecs[1] = '{32'hFFFF_FFFF, 32'd2,        1'b1, 32'h0000_0001, 32'hFFFF_FFFE};
      vecs[2] = '{32'hFFFF_FFFF, 32'd2,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000};
      vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
      vecs[5] = '{32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0000_0000, 32'h0000_0000};
      vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0001};
      vecs[8] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h3FFF_FFFF, 32'h0000_0001};
      vecs[9] = '{32'h1234_5678, 32'h0000_0010, 1'b1, 32'h0000_0001, 32'h2345_6780};

      tick(); tick();
      reset = 1'b0;

      // Reset state.
      check_output("rst_ready", 64'(bus2.ready), 64'd1);
      check_output("rst_busy",  64'(bus2.busy),  64'd0);
      check_output("rst_done",  64'(bus2.done),  64'd0);
      check_output("rst_hi",    64'(bus2.hi),    64'd0);
      check_output("rst_lo",    64'(bus2.lo),    64'd0);

      // Directed vector table.
      foreach (vecs[i]) run_vector(vecs[i], i);

      // start held every cycle with changing operands.
      wait_ready2();
      accepted = 0; dones = 0; last_done = -1;
      pend.delete();
      for (int i = 0; i < 28; i++) begin
         if (i < 20) begin
            apply_stimulus(32'(i * 3 + 1), 32'(100 - i * 7), i[0]);
            start = 1'b1;
            if (bus2.ready) begin
               pend.push_back('{op_a, op_b, is_unsigned});
               accepted++;
            end
         end else begin
            start = 1'b0;
         end
         tick();
         if (i == 1) check_output("busy_in_calc", 64'(bus2.busy), 64'd1);
         if (bus2.done) begin
            dones++;
            if (last_done >= 0)
               check_output("done_spacing", 64'(cyc - last_done), 64'd4);
            last_done = cyc;
            if (pend.size() == 0) begin
               check_output("unexpected_done", 64'd1, 64'd0);
            end else begin
               o = pend.pop_front();
               check_output("burst_result", {bus2.hi, bus2.lo},
                            ref_product(o.a, o.b, o.uns));
            end
         end
      end
      check_output("burst_done_count", 64'(dones), 64'(accepted));

      // Reset in the middle of CALC aborts without a done pulse.
      wait_ready2();
      apply_stimulus(32'd5, 32'd9, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_output("abort_ready", 64'(bus2.ready), 64'd1);
      check_output("abort_busy",  64'(bus2.busy),  64'd0);
      check_output("abort_hilo",  {bus2.hi, bus2.lo}, 64'd0);
      n2 = 0;
      for (int k = 0; k < 6; k++) begin
         if (bus2.done) n2++;
         tick();
      end
      check_output("abort_no_done", 64'(n2), 64'd0);

      // start together with reset: the request is dropped.
      apply_stimulus(32'd3, 32'd4, 1'b0);
      start = 1'b1;
      reset = 1'b1;
      tick();
      start = 1'b0;
      reset = 1'b0;
      check_output("drop_ready", 64'(bus2.ready), 64'd1);
      check_output("drop_busy",  64'(bus2.busy),  64'd0);
      n2 = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus2.done) n2++;
      end
      check_output("drop_no_done", 64'(n2), 64'd0);
      check_output("drop_hilo", {bus2.hi, bus2.lo}, 64'd0);

      // Random signed/unsigned pairs on all three instances.
      for (int r = 0; r < 1000; r++) begin
         ra = $urandom;
         rb = $urandom;
         ru = 1'($urandom_range(0, 1));
         if (!(bus1.ready && bus2.ready && bus3.ready))
            check_output("rand_all_ready", 64'd0, 64'd1);
         apply_stimulus(ra, rb, ru);
         start = 1'b1;
         tick();
         start = 1'b0;
         n1 = 0; n2 = 0; n3 = 0;
         for (int k = 1; k <= 5; k++) begin
            tick();
            if (bus1.done) begin
               n1++;
               check_output("rand_mc1", {bus1.hi, bus1.lo}, ref_product(ra, rb, ru));
            end
            if (bus2.done) n2++;
            if (bus3.done) begin
               n3++;
               check_output("rand_mc3", {bus3.hi, bus3.lo}, ref_product(ra, rb, ru));
            end
         end
         if (n1 != 1) check_output("rand_mc1_done_count", 64'(n1), 64'd1);
         if (n2 != 1) check_output("rand_mc2_done_count", 64'(n2), 64'd1);
         if (n3 != 1) check_output("rand_mc3_done_count", 64'(n3), 64'd1);
         check_output("rand_mc2", {bus2.hi, bus2.lo}, ref_product(ra, rb, ru));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
